lsu_unit: RTL

- Load/store unit sitting directly downstream of compute_core.
- Consumes the core's single outstanding data-memory request (LDR/STR) and sequences the valid/ready handshake to data memory.
- Returns read data plus a one-cycle completion pulse to the core.
- Instantiated in gpu_top beside fetcher; data memory is the external port side.

---
 rtl/lsu_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - load/store unit sequencing one core request onto the data-memory handshake.
// Optional timeout watchdog enabled by defining LSU_TIMEOUT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module lsu_unit #(
  parameter int ADDR_W         = `ADDR_WIDTH,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rd_data_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ready
);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;
  logic       timeout;
  logic       to_fire;

  assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Counter restarts whenever a new wait phase begins.
  always_comb begin
    cnt_d = 8'd0;
    if ((state_d == REQUEST || state_d == WAIT_DATA) && (state_d == state_q))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= to_fire;
    end
  end

  assign resp_error = err_q && (state_q == DONE);
`else
  assign resp_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    to_fire = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (write_q) begin
          if (mem_wr_ready) state_d = DONE;
`ifdef LSU_TIMEOUT_EN
          else if (timeout) begin
            state_d = DONE;
            to_fire = 1'b1;
          end
`endif
        end else begin
          if (mem_rd_ready) begin
            if (mem_rd_data_valid) begin
              rdata_d = mem_rd_data;
              state_d = DONE;
            end else begin
              state_d = WAIT_DATA;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (timeout) begin
            state_d = DONE;
            to_fire = 1'b1;
          end
`endif
        end
      end
      WAIT_DATA: begin
        if (mem_rd_data_valid) begin
          rdata_d = mem_rd_data;
          state_d = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (timeout) begin
          state_d = DONE;
          to_fire = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Address/data come straight from the latched request, so they stay stable while stalled.
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == DONE);
  assign resp_rdata   = rdata_q;
  assign mem_rd_valid = (state_q == REQUEST) && !write_q;
  assign mem_rd_addr  = addr_q;
  assign mem_wr_valid = (state_q == REQUEST) && write_q;
  assign mem_wr_addr  = addr_q;
  assign mem_wr_data  = wdata_q;

endmodule
